// File: rtl/microc_gen_if.sv
// Bus bundle for microc_gen: decoded control strobes and instruction in, CPU state and I/O channels out.
interface microc_gen_if #(
  parameter int NPORTS = 4
);
  logic [15:0]         instr;
  logic                s_inc, s_rel, s_call, s_ret;
  logic                we3, s_inm, s_in, s_out, s_inst;
  logic [2:0]          op;
  logic [8*NPORTS-1:0] in_bus;
  logic [8*NPORTS-1:0] out_bus;
  logic [5:0]          opcode;
  logic                z;
  logic [9:0]          pc;
  logic                full, empty, stk_err;

  modport master (
    output instr, s_inc, s_rel, s_call, s_ret, we3, s_inm, s_in, s_out, s_inst, op, in_bus,
    input  out_bus, opcode, z, pc, full, empty, stk_err
  );
  modport slave (
    input  instr, s_inc, s_rel, s_call, s_ret, we3, s_inm, s_in, s_out, s_inst, op, in_bus,
    output out_bus, opcode, z, pc, full, empty, stk_err
  );
endinterface

// File: rtl/microc_gen.sv
// Single-cycle 8-bit microcontroller datapath: PC/return stack, 16x8 regfile, ALU, NPORTS I/O channels.
module microc_port (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pin,
  input  logic       ld,
  input  logic [7:0] ld_data,
  output logic [7:0] inreg,
  output logic [7:0] dout
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inreg <= '0;
      dout  <= '0;
    end else begin
      inreg <= pin;
      if (ld) dout <= ld_data;
    end
  end
endmodule

module microc_gen #(
  parameter int NPORTS      = 4,
  parameter int STACK_DEPTH = 8,
  parameter int PC_W        = 10
) (
  input logic        clk,
  input logic        reset,
  microc_gen_if.slave bus
);
  localparam int PSEL_W = $clog2(NPORTS);
  localparam int SPW    = $clog2(STACK_DEPTH + 1);
  localparam int SIW    = $clog2(STACK_DEPTH);

  logic [PC_W-1:0]   pc_q, pc_nxt, pc_inc, target;
  logic [SPW-1:0]    sp;
  logic [PC_W-1:0]   stk [STACK_DEPTH];
  logic              z_q, err_q;
  logic              full, empty, illegal, ovf, unf, push, pop;
  logic [SIW-1:0]    top_idx, push_idx;

  logic [7:0]        rf [16];
  logic [3:0]        ra1, ra2, wa3;
  logic [7:0]        rd1, rd2, alu, wd;
  logic [PSEL_W-1:0] port_sel;
  logic [NPORTS-1:0][7:0] inreg, outreg;

  assign ra1      = bus.instr[7:4];
  assign ra2      = bus.instr[11:8];
  assign wa3      = bus.instr[15:12];
  assign target   = bus.instr[15:6];
  assign port_sel = bus.instr[4 +: PSEL_W];

  assign full     = (sp == SPW'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign illegal  = bus.s_call & bus.s_ret;
  assign ovf      = bus.s_call & ~bus.s_ret & full;
  assign unf      = bus.s_ret & ~bus.s_call & empty;
  assign push     = bus.s_call & ~bus.s_ret & ~full;
  assign pop      = bus.s_ret & ~bus.s_call & ~empty;
  assign top_idx  = SIW'(sp - SPW'(1));
  assign push_idx = SIW'(sp);
  assign pc_inc   = pc_q + PC_W'(1);

  // Any stack fault (and the illegal call+ret combo) degrades to a plain step.
  always_comb begin
    pc_nxt = pc_inc;
    if (illegal || ovf || unf) pc_nxt = pc_inc;
    else if (bus.s_ret)        pc_nxt = stk[top_idx];
    else if (bus.s_call)       pc_nxt = target;
    else if (!bus.s_inc)       pc_nxt = target;
    else if (bus.s_rel)        pc_nxt = pc_q + target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      sp    <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else begin
      pc_q <= pc_nxt;
      if (push) begin
        stk[push_idx] <= pc_inc;
        sp            <= sp + SPW'(1);
      end else if (pop) begin
        sp <= sp - SPW'(1);
      end
      if (illegal || ovf || unf) err_q <= 1'b1;
    end
  end

  // r0 is never written, so it reads as zero without a read-side mux.
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  always_comb begin
    alu = '0;
    unique case (bus.op)
      3'b000: alu = rd1;
      3'b001: alu = ~rd1;
      3'b010: alu = rd1 + rd2;
      3'b011: alu = rd1 - rd2;
      3'b100: alu = rd1 & rd2;
      3'b101: alu = rd1 | rd2;
      3'b110: alu = -rd1;
      3'b111: alu = -rd2;
      default: alu = '0;
    endcase
  end

  assign wd = bus.s_in ? inreg[port_sel] : (bus.s_inm ? bus.instr[11:4] : alu);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (bus.we3) begin
      if (wa3 != 4'd0) rf[wa3] <= wd;
      if (!bus.s_in && !bus.s_inm) z_q <= (alu == 8'd0);
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    microc_port u_port (
      .clk     (clk),
      .reset   (reset),
      .pin     (bus.in_bus[8*g +: 8]),
      .ld      (bus.s_out && (port_sel == PSEL_W'(g))),
      .ld_data (bus.s_inst ? bus.instr[15:8] : rd2),
      .inreg   (inreg[g]),
      .dout    (outreg[g])
    );
  end

  assign bus.out_bus = outreg;
  assign bus.opcode  = bus.instr[5:0];
  assign bus.z       = z_q;
  assign bus.pc      = pc_q;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.stk_err = err_q;
endmodule

// File: tb/tb_microc_gen.sv
// Directed scoreboard bench for microc_gen (NPORTS=8, STACK_DEPTH=2).
module tb_microc_gen;
  localparam int NP = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  microc_gen_if #(.NPORTS(NP)) b ();
  microc_gen #(.NPORTS(NP), .STACK_DEPTH(2), .PC_W(10)) dut (.clk(clk), .reset(reset), .bus(b));

  typedef enum int {K_PC, K_Z, K_FULL, K_EMPTY, K_ERR, K_OPC, K_OUT, K_BUS} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    int          ch;
    logic [63:0] v;
  } exp_t;

  exp_t sbq[$];
  int tot = 0;
  int bad = 0;
  logic [7:0] oexp [NP];

  function automatic logic [63:0] observe(kind_t k, int ch);
    case (k)
      K_PC:    return 64'(b.pc);
      K_Z:     return 64'(b.z);
      K_FULL:  return 64'(b.full);
      K_EMPTY: return 64'(b.empty);
      K_ERR:   return 64'(b.stk_err);
      K_OPC:   return 64'(b.opcode);
      K_OUT:   return 64'(b.out_bus[ch*8 +: 8]);
      default: return 64'(b.out_bus);
    endcase
  endfunction

  function automatic logic [63:0] bus_exp();
    logic [63:0] r;
    for (int i = 0; i < NP; i++) r[i*8 +: 8] = oexp[i];
    return r;
  endfunction

  task automatic push(input string tag, input kind_t k, input int ch, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.ch = ch; e.v = v;
    sbq.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [63:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.kind, e.ch);
      tot++;
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic clr();
    b.instr = '0; b.s_inc = 1'b1; b.s_rel = 1'b0; b.s_call = 1'b0; b.s_ret = 1'b0;
    b.we3 = 1'b0; b.s_inm = 1'b0; b.s_in = 1'b0; b.s_out = 1'b0; b.s_inst = 1'b0; b.op = '0;
  endtask

  task automatic do_jmp(input logic [9:0] t);
    clr(); b.s_inc = 1'b0; b.instr = {t, 6'h0};
  endtask
  task automatic do_call(input logic [9:0] t);
    clr(); b.s_call = 1'b1; b.instr = {t, 6'h0};
  endtask
  task automatic do_ret();
    clr(); b.s_ret = 1'b1;
  endtask
  task automatic wr_imm(input logic [3:0] r, input logic [7:0] v);
    clr(); b.we3 = 1'b1; b.s_inm = 1'b1; b.instr = {r, v, 4'h0};
  endtask
  task automatic alu(input logic [2:0] op, input logic [3:0] wa, input logic [3:0] ra1, input logic [3:0] ra2);
    clr(); b.we3 = 1'b1; b.op = op; b.instr = {wa, ra2, ra1, 4'h0};
  endtask
  task automatic out_reg(input logic [3:0] r, input logic [2:0] port, input logic [7:0] expv);
    clr(); b.s_out = 1'b1; b.instr = {4'h0, r, 1'b0, port, 4'h0};
    oexp[port] = expv;
    push("out_reg", K_OUT, int'(port), 64'(expv));
  endtask
  task automatic out_imm(input logic [7:0] v, input logic [2:0] port);
    clr(); b.s_out = 1'b1; b.s_inst = 1'b1; b.instr = {v, 1'b0, port, 4'h0};
    oexp[port] = v;
  endtask

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] bb);
    case (op)
      3'd0: return a;
      3'd1: return ~a;
      3'd2: return a + bb;
      3'd3: return a - bb;
      3'd4: return a & bb;
      3'd5: return a | bb;
      3'd6: return 8'd0 - a;
      default: return 8'd0 - bb;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rv;
    for (int i = 0; i < NP; i++) oexp[i] = 8'h00;
    b.in_bus = '0;
    clr();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_pc", K_PC, 0, 0);     push("rst_z", K_Z, 0, 0);
    push("rst_empty", K_EMPTY, 0, 1); push("rst_full", K_FULL, 0, 0);
    push("rst_err", K_ERR, 0, 0);   push("rst_bus", K_BUS, 0, 0);
    check();
    reset = 1'b1;

    // absolute then relative jump with wrap
    repeat (4) tick();
    push("pc_seq5", K_PC, 0, 5); tick();
    b.instr = 16'h002A; push("opcode", K_OPC, 0, 64'h2A); check();
    do_jmp(10'h3F0); push("jmp_abs", K_PC, 0, 10'h3F0); tick();
    clr(); b.s_rel = 1'b1; b.instr = {10'h020, 6'h0};
    push("jmp_rel_wrap", K_PC, 0, 10'h010); tick();

    // nested calls and returns
    do_jmp(10'd1); push("jmp1", K_PC, 0, 1); tick();
    do_call(10'd10); push("call1_pc", K_PC, 0, 10); push("call1_empty", K_EMPTY, 0, 0);
    push("call1_full", K_FULL, 0, 0); tick();
    do_call(10'd20); push("call2_pc", K_PC, 0, 20); push("call2_full", K_FULL, 0, 1); tick();
    do_ret(); push("ret1_pc", K_PC, 0, 11); push("ret1_full", K_FULL, 0, 0); tick();
    do_ret(); push("ret2_pc", K_PC, 0, 2); push("ret2_empty", K_EMPTY, 0, 1);
    push("ret2_err", K_ERR, 0, 0); tick();

    // overflow
    do_call(10'd30); push("c30", K_PC, 0, 30); tick();
    do_call(10'd40); push("c40", K_PC, 0, 40); push("c40_full", K_FULL, 0, 1); tick();
    do_call(10'd50); push("ovf_pc", K_PC, 0, 41); push("ovf_full", K_FULL, 0, 1);
    push("ovf_err", K_ERR, 0, 1); tick();
    do_ret(); push("ovf_ret_pc", K_PC, 0, 31); push("ovf_err_sticky", K_ERR, 0, 1); tick();

    // reset clears error, then underflow
    clr(); reset = 1'b0; #1;
    push("rst2_pc", K_PC, 0, 0); push("rst2_err", K_ERR, 0, 0); push("rst2_empty", K_EMPTY, 0, 1);
    check();
    @(posedge clk); #1; reset = 1'b1;
    do_ret(); push("unf_pc", K_PC, 0, 1); push("unf_err", K_ERR, 0, 1);
    push("unf_empty", K_EMPTY, 0, 1); tick();
    clr(); push("unf_idle_pc", K_PC, 0, 2); push("unf_err_sticky", K_ERR, 0, 1); tick();

    // illegal call+ret
    reset = 1'b0; #1; @(posedge clk); #1; reset = 1'b1;
    do_call(10'd7); push("ill_setup_pc", K_PC, 0, 7); push("ill_setup_err", K_ERR, 0, 0); tick();
    clr(); b.s_call = 1'b1; b.s_ret = 1'b1; b.instr = {10'd99, 6'h0};
    push("ill_pc", K_PC, 0, 8); push("ill_empty", K_EMPTY, 0, 0);
    push("ill_full", K_FULL, 0, 0); push("ill_err", K_ERR, 0, 1); tick();
    do_ret(); push("ill_ret_pc", K_PC, 0, 1); push("ill_ret_empty", K_EMPTY, 0, 1); tick();

    // reset in the middle of a call cycle
    do_call(10'd200); #2; reset = 1'b0; #1;
    push("midrst_pc", K_PC, 0, 0); push("midrst_empty", K_EMPTY, 0, 1); check();
    @(posedge clk); #1;
    push("midrst_hold_pc", K_PC, 0, 0); push("midrst_hold_empty", K_EMPTY, 0, 1); check();
    clr(); reset = 1'b1;

    // ALU and zero flag
    wr_imm(4'd1, 8'd5); tick();
    wr_imm(4'd2, 8'd5); tick();
    alu(3'b011, 4'd3, 4'd1, 4'd2); push("sub_z", K_Z, 0, 1); tick();
    out_imm(8'hFF, 3'd2); tick();
    out_reg(4'd3, 3'd2, 8'h00); tick();
    alu(3'b010, 4'd3, 4'd1, 4'd2); push("add_z", K_Z, 0, 0); tick();
    out_reg(4'd3, 3'd1, 8'h0A); tick();
    out_imm(8'hFF, 3'd3); tick();
    wr_imm(4'd0, 8'h77); push("r0_imm_zhold", K_Z, 0, 0); tick();
    out_reg(4'd0, 3'd3, 8'h00); push("bus_after_r0", K_BUS, 0, bus_exp()); tick();

    wr_imm(4'd2, 8'd3); tick();
    for (int o = 0; o < 8; o++) begin
      rv = alu_ref(3'(o), 8'd5, 8'd3);
      alu(3'(o), 4'd3, 4'd1, 4'd2); push("alu_z", K_Z, 0, 64'(rv == 8'd0)); tick();
      out_reg(4'd3, 3'd1, rv); tick();
    end

    // I/O: set z=1 first so the s_in write can be seen to hold it
    alu(3'b011, 4'd5, 4'd1, 4'd1); push("self_sub_z", K_Z, 0, 1); tick();
    clr(); b.in_bus[6*8 +: 8] = 8'hA5; tick();
    clr(); b.we3 = 1'b1; b.s_in = 1'b1; b.instr = {4'h4, 4'h0, 1'b0, 3'd6, 4'h0};
    push("in_zhold", K_Z, 0, 1); tick();
    out_reg(4'd4, 3'd5, 8'hA5); tick();
    out_imm(8'h3C, 3'd7); push("out7_imm", K_OUT, 7, 64'h3C); push("bus_final", K_BUS, 0, bus_exp());
    tick();
    clr(); push("bus_idle_hold", K_BUS, 0, bus_exp()); tick();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
